// File: rtl/mem_access_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared definitions for the memory-access pipeline stage:
//   - DATA_W     : datapath width (32)
//   - SIZE_WORD / SIZE_BYTE : access-size encoding of the *_source_in inputs
//   - state_e    : FSM state encoding (IDLE, ACCESS, WAIT)
//   - lane_onehot: byte-lane one-hot decode of an address offset
// ----------------------------------------------------------------------------
package mem_access_stage_pkg;

    localparam int   DATA_W    = 32;
    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_e;

    // One-hot byte-lane select for a byte offset within a word.
    function automatic logic [3:0] lane_onehot(input logic [1:0] byte_off);
        logic [3:0] lane;
        case (byte_off)
            2'd0:    lane = 4'b0001;
            2'd1:    lane = 4'b0010;
            2'd2:    lane = 4'b0100;
            2'd3:    lane = 4'b1000;
            default: lane = 4'b0000;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ----------------------------------------------------------------------------
// mem_lane_align
// Pure combinational lane steering for the data-memory port.
// Ports:
//   size       in  1   access size (SIZE_WORD / SIZE_BYTE)
//   byte_off   in  2   address bits [1:0]
//   store_data in  32  register store data
//   rdata      in  32  raw read data from memory
//   be         out 4   byte enables (before request gating)
//   wdata      out 32  write data (byte stores replicated to all lanes)
//   load_data  out 32  load result (byte loads zero-extended)
// ----------------------------------------------------------------------------
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic              size,
    input  logic [1:0]        byte_off,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data
);

    // Steer store lanes and extract the addressed load lane.
    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        if (size == SIZE_BYTE) begin
            be    = lane_onehot(byte_off);
            wdata = {4{store_data[7:0]}};
            case (byte_off)
                2'd0:    load_data = {24'd0, rdata[7:0]};
                2'd1:    load_data = {24'd0, rdata[15:8]};
                2'd2:    load_data = {24'd0, rdata[23:16]};
                2'd3:    load_data = {24'd0, rdata[31:24]};
                default: load_data = 32'd0;
            endcase
        end else begin
            be        = 4'b1111;
            wdata     = store_data;
            load_data = rdata;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// ----------------------------------------------------------------------------
// mem_access_stage
// MEM stage of an in-order pipeline: issues one data-memory access per
// load/store through an IDLE -> ACCESS -> WAIT handshake, stalls upstream
// until the access completes, and registers the MEM/WB outputs.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- misaligned word accesses are
// dropped (no request, no stall) and flagged on misalign_out.
// Ports:
//   clk, rst                 clock, async active-low reset
//   *_in                     EX/MEM pipeline inputs (held by upstream on stall)
//   dmem_*                   data-memory request/response port
//   stall_out, pc_src_out    combinational pipeline controls
//   read_data_out .. misalign_out  registered MEM/WB outputs
// ----------------------------------------------------------------------------
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] reg_file_out_2_in,
    input  logic [4:0]  register_destination_in,
    input  logic        zero_flag_in,
    input  logic        branch_in,
    input  logic        memory_read_in,
    input  logic        memory_write_in,
    input  logic        memory_read_source_in,
    input  logic        memory_write_source_in,
    input  logic        memory_to_register_in,
    input  logic        reg_write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        pc_src_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  register_destination_out,
    output logic        reg_write_out,
    output logic        memory_to_register_out,
    output logic        misalign_out
);

    state_e      state_q, state_d;
    logic        access_s, size_s, misalign_s, pending_s, complete_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s, load_data_s;

    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [4:0]  reg_dest_q, reg_dest_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        misalign_q, misalign_d;

    mem_lane_align u_lane (
        .size       (size_s),
        .byte_off   (alu_result_in[1:0]),
        .store_data (reg_file_out_2_in),
        .rdata      (dmem_rdata),
        .be         (be_s),
        .wdata      (wdata_s),
        .load_data  (load_data_s)
    );

    // Decode the request; a store's size wins if both strobes are set.
    always_comb begin
        access_s = memory_read_in | memory_write_in;
        if (memory_write_in) begin
            size_s = memory_write_source_in;
        end else begin
            size_s = memory_read_source_in;
        end
`ifdef MEM_ALIGN_CHECK_EN
        misalign_s = access_s & (size_s == SIZE_WORD) & (alu_result_in[1:0] != 2'b00);
`else
        misalign_s = 1'b0;
`endif
    end

    // FSM next state, request and stall generation.
    always_comb begin
        state_d    = state_q;
        pending_s  = 1'b0;
        dmem_req   = 1'b0;
        complete_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_s & ~misalign_s) begin
                    pending_s = 1'b1;
                    state_d   = ACCESS;
                end else begin
                    state_d   = IDLE;
                end
            end
            ACCESS: begin
                // Any ack here is stale and deliberately ignored.
                pending_s = 1'b1;
                dmem_req  = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                pending_s = 1'b1;
                dmem_req  = 1'b1;
                if (dmem_ack) begin
                    complete_s = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d    = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        stall_out  = pending_s & ~complete_s;
        pc_src_out = branch_in & zero_flag_in & ~stall_out;
    end

    // Memory port: enables are gated by the request so they are quiet in IDLE and reset.
    always_comb begin
        dmem_addr  = {alu_result_in[31:2], 2'b00};
        dmem_wdata = wdata_s;
        if (dmem_req) begin
            dmem_we = memory_write_in;
            dmem_be = be_s;
        end else begin
            dmem_we = 1'b0;
            dmem_be = 4'b0000;
        end
    end

    // MEM/WB next values: a bubble while stalled, otherwise the retiring instruction.
    always_comb begin
        read_data_d  = 32'd0;
        alu_result_d = 32'd0;
        reg_dest_d   = 5'd0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        misalign_d   = 1'b0;
        if (stall_out) begin
            reg_write_d = 1'b0;
        end else begin
            alu_result_d = alu_result_in;
            reg_dest_d   = register_destination_in;
            mem_to_reg_d = memory_to_register_in;
            if (misalign_s) begin
                misalign_d  = 1'b1;
                reg_write_d = 1'b0;
            end else begin
                reg_write_d = reg_write_in;
                if (complete_s & ~memory_write_in) begin
                    read_data_d = load_data_s;
                end else begin
                    read_data_d = 32'd0;
                end
            end
        end
    end

    // State and MEM/WB registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            read_data_q  <= 32'd0;
            alu_result_q <= 32'd0;
            reg_dest_q   <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            reg_dest_q   <= reg_dest_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            misalign_q   <= misalign_d;
        end
    end

    assign read_data_out            = read_data_q;
    assign alu_result_out           = alu_result_q;
    assign register_destination_out = reg_dest_q;
    assign reg_write_out            = reg_write_q;
    assign memory_to_register_out   = mem_to_reg_q;
    assign misalign_out             = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_access_stage
// Self-checking bench for mem_access_stage. Expected MEM/WB results are
// queued when an instruction is driven and popped when it retires; a small
// memory responder inside the access task returns ack after a chosen delay.
// ----------------------------------------------------------------------------
module tb_mem_access_stage;

    logic        clk, rst;
    logic [31:0] alu_result_in, reg_file_out_2_in;
    logic [4:0]  register_destination_in;
    logic        zero_flag_in, branch_in, memory_read_in, memory_write_in;
    logic        memory_read_source_in, memory_write_source_in;
    logic        memory_to_register_in, reg_write_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall_out, pc_src_out;
    logic [31:0] read_data_out, alu_result_out;
    logic [4:0]  register_destination_out;
    logic        reg_write_out, memory_to_register_out, misalign_out;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic        rw;
        logic        m2r;
        logic        mis;
    } wb_t;

    wb_t sb_q[$];
    int  n_compared, n_mismatched;
    int  last_stalls;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;

    mem_access_stage dut (
        .clk                      (clk),
        .rst                      (rst),
        .alu_result_in            (alu_result_in),
        .reg_file_out_2_in        (reg_file_out_2_in),
        .register_destination_in  (register_destination_in),
        .zero_flag_in             (zero_flag_in),
        .branch_in                (branch_in),
        .memory_read_in           (memory_read_in),
        .memory_write_in          (memory_write_in),
        .memory_read_source_in    (memory_read_source_in),
        .memory_write_source_in   (memory_write_source_in),
        .memory_to_register_in    (memory_to_register_in),
        .reg_write_in             (reg_write_in),
        .dmem_req                 (dmem_req),
        .dmem_we                  (dmem_we),
        .dmem_addr                (dmem_addr),
        .dmem_wdata               (dmem_wdata),
        .dmem_be                  (dmem_be),
        .dmem_ack                 (dmem_ack),
        .dmem_rdata               (dmem_rdata),
        .stall_out                (stall_out),
        .pc_src_out               (pc_src_out),
        .read_data_out            (read_data_out),
        .alu_result_out           (alu_result_out),
        .register_destination_out (register_destination_out),
        .reg_write_out            (reg_write_out),
        .memory_to_register_out   (memory_to_register_out),
        .misalign_out             (misalign_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_be(input logic is_byte, input logic [1:0] off);
        logic [3:0] one;
        one = 4'b0001;
        return is_byte ? (one << off) : 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic is_byte, input logic [31:0] d);
        return is_byte ? {d[7:0], d[7:0], d[7:0], d[7:0]} : d;
    endfunction

    function automatic logic [31:0] model_load(input logic is_byte, input logic [1:0] off, input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> (8 * off);
        return is_byte ? (sh & 32'h0000_00FF) : d;
    endfunction

    task automatic set_nop();
        alu_result_in           = 32'd0;
        reg_file_out_2_in       = 32'd0;
        register_destination_in = 5'd0;
        zero_flag_in            = 1'b0;
        branch_in               = 1'b0;
        memory_read_in          = 1'b0;
        memory_write_in         = 1'b0;
        memory_read_source_in   = 1'b0;
        memory_write_source_in  = 1'b0;
        memory_to_register_in   = 1'b0;
        reg_write_in            = 1'b0;
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_read_data"}, read_data_out, e.rd);
            check({tag, "_alu_result"}, alu_result_out, e.alu);
            check({tag, "_reg_dest"}, 32'(register_destination_out), 32'(e.dst));
            check({tag, "_reg_write"}, 32'(reg_write_out), 32'(e.rw));
            check({tag, "_mem_to_reg"}, 32'(memory_to_register_out), 32'(e.m2r));
            check({tag, "_misalign"}, 32'(misalign_out), 32'(e.mis));
        end
    endtask

    task automatic do_alu(input string tag, input logic [31:0] res, input logic [4:0] dst,
                          input logic rw, input logic br, input logic zf);
        wb_t e;
        @(negedge clk);
        set_nop();
        alu_result_in = res; register_destination_in = dst; reg_write_in = rw;
        branch_in = br; zero_flag_in = zf;
        e.rd = 32'd0; e.alu = res; e.dst = dst; e.rw = rw; e.m2r = 1'b0; e.mis = 1'b0;
        sb_q.push_back(e);
        #1;
        check({tag, "_stall"}, 32'(stall_out), 32'd0);
        check({tag, "_pc_src"}, 32'(pc_src_out), 32'(br & zf));
        @(negedge clk);
        check_wb(tag);
        set_nop();
    endtask

    task automatic do_mem(input string tag, input logic is_wr, input logic is_byte,
                          input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                          input int ack_d, input logic spurious, input logic [4:0] dst, input logic rw);
        wb_t  e;
        logic mis, done, stable, ack;
        int   stalls, idx, exp_cnt;
        logic [31:0] a0, w0;
        logic [3:0]  b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = !is_byte && (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        exp_cnt = mis ? 0 : ack_d + 1;
        e.rd  = (is_wr || mis) ? 32'd0 : model_load(is_byte, addr[1:0], rdata);
        e.alu = addr; e.dst = dst; e.rw = mis ? 1'b0 : rw; e.m2r = !is_wr; e.mis = mis;
        @(negedge clk);
        set_nop();
        alu_result_in = addr; reg_file_out_2_in = sdata; register_destination_in = dst;
        memory_read_in = !is_wr; memory_write_in = is_wr;
        memory_read_source_in = is_byte; memory_write_source_in = is_byte;
        memory_to_register_in = !is_wr; reg_write_in = rw;
        branch_in = 1'b1; zero_flag_in = 1'b1;
        dmem_ack = 1'b0; dmem_rdata = ~rdata;
        sb_q.push_back(e);
        stalls = 0; idx = 0; done = 1'b0; stable = 1'b1;
        a0 = 32'd0; w0 = 32'd0; b0 = 4'd0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            ack = dmem_req && ((idx == ack_d) || (spurious && idx == 0));
            dmem_ack = ack;
            dmem_rdata = ack ? rdata : ~rdata;
            #1;
            if (c == 0) check({tag, "_pc_src_first"}, 32'(pc_src_out), 32'(mis));
            if (dmem_req) begin
                if (idx == 0) begin
                    a0 = dmem_addr; w0 = dmem_wdata; b0 = dmem_be;
                end else if (a0 !== dmem_addr || w0 !== dmem_wdata || b0 !== dmem_be) begin
                    stable = 1'b0;
                end
                check({tag, "_we"}, 32'(dmem_we), 32'(is_wr));
                idx++;
            end
            if (stall_out) stalls++;
            else done = 1'b1;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_cnt));
        check({tag, "_req_cycles"}, 32'(idx), 32'(exp_cnt));
        if (exp_cnt != 0) begin
            check({tag, "_addr"}, a0, {addr[31:2], 2'b00});
            check({tag, "_be"}, 32'(b0), 32'(model_be(is_byte, addr[1:0])));
            check({tag, "_wdata"}, w0, model_wdata(is_byte, sdata));
            check({tag, "_stable"}, 32'(stable), 32'd1);
        end
        last_stalls = stalls; last_addr = a0; last_wdata = w0; last_be = b0;
        @(negedge clk);
        dmem_ack = 1'b0;
        check_wb(tag);
        set_nop();
    endtask

    initial begin
        n_compared = 0; n_mismatched = 0;
        clk = 1'b0; rst = 1'b0;
        set_nop();
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_dmem_be", 32'(dmem_be), 32'd0);
        check("rst_read_data", read_data_out, 32'd0);
        check("rst_alu_result", alu_result_out, 32'd0);
        check("rst_reg_write", 32'(reg_write_out), 32'd0);
        check("rst_misalign", 32'(misalign_out), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        rst = 1'b1;

        do_alu("alu_a", 32'h1234_5678, 5'd3, 1'b1, 1'b0, 1'b0);
        do_alu("br_taken", 32'h0000_0040, 5'd0, 1'b0, 1'b1, 1'b1);
        do_alu("br_not_zero", 32'h0000_0044, 5'd0, 1'b0, 1'b1, 1'b0);

        do_mem("word_load", 1'b0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 3, 1'b0, 5'd7, 1'b1);
        check("word_load_stall4", 32'(last_stalls), 32'd4);
        do_mem("byte_store", 1'b1, 1'b1, 32'h23, 32'h0000_00A5, 32'd0, 1, 1'b0, 5'd0, 1'b0);
        check("byte_store_be", 32'(last_be), 32'h8);
        check("byte_store_wdata", last_wdata, 32'hA5A5_A5A5);
        check("byte_store_addr", last_addr, 32'h20);
        do_mem("byte_load", 1'b0, 1'b1, 32'h11, 32'd0, 32'h1122_3344, 1, 1'b0, 5'd9, 1'b1);
        check("byte_load_value", read_data_out, 32'h0000_0033);
        do_mem("min_wait", 1'b0, 1'b0, 32'h100, 32'd0, 32'hCAFE_F00D, 1, 1'b0, 5'd1, 1'b1);
        check("min_wait_stall2", 32'(last_stalls), 32'd2);
        do_mem("stale_ack", 1'b0, 1'b0, 32'h204, 32'd0, 32'h0BAD_F00D, 2, 1'b1, 5'd2, 1'b1);
        do_mem("word_store", 1'b1, 1'b0, 32'h30, 32'h89AB_CDEF, 32'd0, 2, 1'b0, 5'd4, 1'b1);
        do_mem("unaligned_word", 1'b0, 1'b0, 32'h12, 32'd0, 32'h5566_7788, 1, 1'b0, 5'd5, 1'b1);
        do_alu("after_unaligned", 32'h0000_0ABC, 5'd6, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            do_mem("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                   $urandom, $urandom, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                   5'($urandom), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset with live WB contents.
        @(negedge clk);
        set_nop();
        alu_result_in = 32'hA5A5_0001; register_destination_in = 5'd12; reg_write_in = 1'b1;
        @(negedge clk);
        check("pre_rst_alu", alu_result_out, 32'hA5A5_0001);
        #1 rst = 1'b0;
        #1;
        check("async_rst_alu", alu_result_out, 32'd0);
        check("async_rst_dest", 32'(register_destination_out), 32'd0);
        check("async_rst_reg_write", 32'(reg_write_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        set_nop();

        // Reset while waiting for ack aborts the access.
        @(negedge clk);
        alu_result_in = 32'h40; memory_read_in = 1'b1; memory_to_register_in = 1'b1; reg_write_in = 1'b1;
        register_destination_in = 5'd8;
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("wait_req_before_rst", 32'(dmem_req), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_dmem_req", 32'(dmem_req), 32'd0);
        check("abort_dmem_we", 32'(dmem_we), 32'd0);
        check("abort_dmem_be", 32'(dmem_be), 32'd0);
        check("abort_read_data", read_data_out, 32'd0);
        check("abort_reg_write", 32'(reg_write_out), 32'd0);
        check("abort_mem_to_reg", 32'(memory_to_register_out), 32'd0);
        set_nop();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("no_retry_req", 32'(dmem_req), 32'd0);
            check("no_retry_stall", 32'(stall_out), 32'd0);
        end
        do_alu("post_rst", 32'h7777_0000, 5'd31, 1'b1, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, ports listed first.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
REQ-002 EX/MEM-side inputs SHALL be:
- alu_result_in  in  32  address or ALU result.
- reg_file_out_2_in  in  32  store data.
- register_destination_in  in  5  destination register.
- zero_flag_in, branch_in  in  1 each  branch resolution inputs.
- memory_read_in, memory_write_in  in  1 each  access request.
- memory_read_source_in, memory_write_source_in  in  1 each  0 = word, 1 = byte.
- memory_to_register_in, reg_write_in  in  1 each  write-back controls.
REQ-003 Data-memory port SHALL be:
- dmem_req  out  1  request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word address, bits [1:0] = 0.
- dmem_wdata  out  32  write data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  completion.
- dmem_rdata  in  32  read data.
REQ-004 Pipeline and write-back outputs SHALL be:
- stall_out  out  1  freeze upstream stages.
- pc_src_out  out  1  branch taken.
- The following registered outputs toward MEM/WB: read_data_out (32), alu_result_out (32), register_destination_out (5), reg_write_out (1), memory_to_register_out (1), misalign_out (1).

Function
REQ-005 The FSM SHALL have states IDLE, ACCESS, and WAIT.
REQ-006 In IDLE, if (memory_read_in | memory_write_in), then in the same cycle stall_out SHALL be 1 and the next state SHALL be ACCESS; otherwise the WB registers SHALL capture the inputs at the next edge, with read_data_out = 0.
REQ-007 In ACCESS, dmem_req SHALL be 1, with addr, we, wdata and be held stable, and the next state SHALL be WAIT.
REQ-008 In WAIT, dmem_req SHALL remain 1 until dmem_ack = 1. A cycle with ack SHALL:
- deassert stall_out combinationally;
- load the WB registers at the edge;
- return the FSM to IDLE.
REQ-009 stall_out SHALL equal pending & ~(state==WAIT & dmem_ack); with zero-wait ack, the minimum access costs 2 stall cycles.
REQ-010 Inputs SHALL be held stable by upstream while stall_out = 1; the block SHALL NOT re-latch them.
REQ-011 Word accesses SHALL use dmem_be = 4'b1111 and dmem_wdata = store data.
REQ-012 Byte stores SHALL replicate store data [7:0] to all lanes and set one dmem_be bit = 1 << alu_result_in[1:0].
REQ-013 Byte loads SHALL zero-extend lane alu_result_in[1:0] of dmem_rdata; word loads SHALL pass dmem_rdata unchanged.
REQ-014 For a store, read_data_out SHALL be 0, and reg_write_out SHALL pass reg_write_in unchanged.
REQ-015 pc_src_out SHALL be combinational: branch_in & zero_flag_in & ~stall_out.
REQ-016 dmem_ack outside WAIT SHALL be ignored.
REQ-017 Reset asserted mid-access SHALL abort the access with no retry.

Reset
REQ-018 While rst = 0, the block SHALL hold the following low or zero:
- the FSM, in state IDLE;
- all registered outputs;
- dmem_req, dmem_we, and dmem_be.
REQ-019 Reset SHALL take effect asynchronously; release SHALL be sampled on clk.

Configuration
REQ-020 With MEM_ALIGN_CHECK_EN defined, a word access with alu_result_in[1:0] != 0 SHALL:
- skip ACCESS and WAIT, with no dmem_req and no stall;
- set misalign_out = 1 for one WB cycle;
- force reg_write_out = 0.
REQ-021 Without MEM_ALIGN_CHECK_EN, misalign_out SHALL be tied to 0 and the low address bits SHALL be ignored for word accesses.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding, the access-size constants (SIZE_WORD = 0, SIZE_BYTE = 1), and the data width of 32.
REQ-023 A single sub-module mem_lane_align SHALL compute dmem_be, the replicated wdata, and load extraction.

Verification
REQ-024 Word load at 0x10 with ack 3 cycles after req, rdata = 0xDEADBEEF -> stall for 4 cycles, then read_data_out = 0xDEADBEEF and reg_write_out = 1.
REQ-025 Byte store of 0x000000A5 at 0x23 -> dmem_be = 4'b1000, dmem_wdata = 0xA5A5A5A5, addr = 0x20.
REQ-026 Byte load at 0x11, rdata = 0x11223344 -> read_data_out = 0x00000033.
REQ-027 branch_in = 1 and zero_flag_in = 1 with no access -> pc_src_out = 1 and stall_out = 0 in the same cycle.
REQ-028 rst driven low during WAIT -> dmem_req = 0 immediately, FSM in IDLE, all outputs zero.
REQ-029 MEM_ALIGN_CHECK_EN defined, word load at 0x12 -> no dmem_req, misalign_out = 1, reg_write_out = 0.
